// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared definitions for the sequential multiply-accumulate block:
//   FSM state encoding and the default width constants used as parameter
//   defaults by mac_seq and mac_seq_dp.
package mac_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MUL_WIDTH  = 32;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_dp.sv
// mac_seq_dp
//   Datapath of the dot-product engine: a registered signed multiplier
//   followed by a saturating accumulator with a sticky overflow flag.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     i_clr        clear accumulator and overflow flag (start of operation)
//     i_accept     operand pair handshake this cycle
//     i_a, i_b     signed operands
//     o_acc        accumulator value (signed, saturated)
//     o_ovf        saturation has occurred since the last clear
module mac_seq_dp
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MUL_WIDTH  = DEF_MUL_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_accept,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_ovf
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [MUL_WIDTH-1:0] r_prod;
  logic                 r_prod_vld;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  logic signed [MUL_WIDTH-1:0] w_a_ext;
  logic signed [MUL_WIDTH-1:0] w_b_ext;
  logic signed [MUL_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_sat;
  logic [ACC_WIDTH-1:0]        w_acc_next;

  // Sign-extend before multiplying so the low MUL_WIDTH bits are the exact
  // signed product.
  assign w_a_ext = {{(MUL_WIDTH-DATA_WIDTH){i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext = {{(MUL_WIDTH-DATA_WIDTH){i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // One guard bit: the two top bits differ exactly when the add overflowed.
  assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
               + {{(ACC_WIDTH+1-MUL_WIDTH){r_prod[MUL_WIDTH-1]}}, r_prod};
  assign w_sat = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_sat) begin
      w_acc_next = w_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_prod_vld <= i_accept;
      if (i_accept) begin
        r_prod <= w_prod;
      end
      if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_prod_vld) begin
        r_acc <= w_acc_next;
        r_ovf <= r_ovf | w_sat;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_seq.sv
// mac_seq
//   Sequential signed dot-product engine. A start request captures the pair
//   count; pairs are then accepted through a valid/ready handshake, multiplied
//   and accumulated with saturation, and the result is presented with a
//   valid/ready handshake.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     start, len           begin an operation of len pairs (IDLE only)
//     busy                 not idle
//     op_valid, op_ready   operand pair handshake
//     a_in, b_in           signed operands
//     res_valid, res_ready result handshake
//     res_data, res_ovf    saturated dot product and saturation flag
module mac_seq
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MUL_WIDTH  = DEF_MUL_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_ovf
);

  state_t               r_state;
  state_t               w_state_next;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 w_op_ready;
  logic                 w_res_valid;
  logic                 w_clr;
  logic                 w_accept;

  assign w_accept = w_op_ready & op_valid;

  always_comb begin
    w_state_next = r_state;
    w_op_ready   = 1'b0;
    w_res_valid  = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr        = 1'b1;
          w_state_next = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_op_ready = 1'b1;
        if (op_valid && r_count == LEN_WIDTH'(1)) begin
          w_state_next = ST_DRAIN;
        end
      end
      // Last product is folded into the accumulator on this cycle's edge.
      ST_DRAIN: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start) begin
        r_count <= len;
      end else if (w_accept) begin
        r_count <= r_count - LEN_WIDTH'(1);
      end
    end
  end

  mac_seq_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_WIDTH  (MUL_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_accept (w_accept),
    .i_a      (a_in),
    .i_b      (b_in),
    .o_acc    (res_data),
    .o_ovf    (res_ovf)
  );

  assign busy      = (r_state != ST_IDLE);
  assign op_ready  = w_op_ready;
  assign res_valid = w_res_valid;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq
//   Drives two mac_seq instances (40-bit and 32-bit accumulators) with the
//   same stimulus and compares both against a plain-arithmetic dot product
//   model with per-step saturation.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        op_valid;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        res_ready;

  logic        busy40, op_ready40, res_valid40, res_ovf40;
  logic [39:0] res_data40;
  logic        busy32, op_ready32, res_valid32, res_ovf32;
  logic [31:0] res_data32;

  int n_tests = 0;
  int n_fail  = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  mac_seq #(.ACC_WIDTH(40)) u_dut40 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy40),
    .op_valid(op_valid), .op_ready(op_ready40), .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid40), .res_ready(res_ready), .res_data(res_data40),
    .res_ovf(res_ovf40)
  );

  mac_seq #(.ACC_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy32),
    .op_valid(op_valid), .op_ready(op_ready32), .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid32), .res_ready(res_ready), .res_data(res_data32),
    .res_ovf(res_ovf32)
  );

  task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dot product of the first n queued pairs, clamped after every addition.
  task automatic model(input int n, input int w, output longint acc, output bit ovf);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(qa[i]) * longint'(qb[i]);
      if (acc > hi) begin acc = hi; ovf = 1'b1; end
      if (acc < lo) begin acc = lo; ovf = 1'b1; end
    end
  endtask

  task automatic check_result(input string tag, input longint e40, input bit o40,
                              input longint e32, input bit o32);
    tb_check({tag, "_data40"}, longint'($signed(res_data40)), e40);
    tb_check({tag, "_ovf40"}, res_ovf40, o40);
    tb_check({tag, "_data32"}, longint'($signed(res_data32)), e32);
    tb_check({tag, "_ovf32"}, res_ovf32, o32);
  endtask

  // One complete operation using qa/qb; hold = cycles res_ready stays low in DONE.
  task automatic do_dot(input string tag, input int n, input int hold, input int max_gap);
    longint e40, e32;
    bit     o40, o32;
    int     hs;
    int     ta, tb;
    model(n, 40, e40, o40);
    model(n, 32, e32, o32);
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    len   = 8'd0;
    hs    = 0;
    if (n == 0) begin
      tb_check({tag, "_len0_valid"}, res_valid40, 1'b1);
      tb_check({tag, "_len0_ready"}, op_ready40, 1'b0);
    end else begin
      tb_check({tag, "_busy"}, busy40, 1'b1);
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) begin
          op_valid = 1'b0;
          tb_check({tag, "_stall_ready"}, op_ready40, 1'b1);
          @(negedge clk);
        end
        ta = qa[i];
        tb = qb[i];
        op_valid = 1'b1;
        a_in     = ta[15:0];
        b_in     = tb[15:0];
        if (op_ready40 && op_ready32) hs++;
        @(negedge clk);
      end
      op_valid = 1'b0;
      tb_check({tag, "_ready_after_last"}, op_ready40, 1'b0);
      tb_check({tag, "_valid_drain"}, res_valid40, 1'b0);
      @(negedge clk);
      tb_check({tag, "_valid_2edges"}, res_valid40, 1'b1);
      tb_check({tag, "_handshakes"}, hs, n);
    end
    check_result(tag, e40, o40, e32, o32);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = 8'd5;
      @(negedge clk);
      tb_check({tag, "_hold_valid"}, res_valid40, 1'b1);
      tb_check({tag, "_hold_ready"}, op_ready40, 1'b0);
      check_result({tag, "_hold"}, e40, o40, e32, o32);
    end
    start     = 1'b0;
    len       = 8'd0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tb_check({tag, "_valid_drop"}, res_valid40, 1'b0);
    tb_check({tag, "_idle"}, busy40, 1'b0);
    $display("[TB] %s len=%0d res40=%0d ovf40=%0d res32=%0d ovf32=%0d",
             tag, n, $signed(res_data40), res_ovf40, $signed(res_data32), res_ovf32);
  endtask

  task automatic set_pairs(input int n, input int va, input int vb);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(va);
      qb.push_back(vb);
    end
  endtask

  task automatic check_zero(input string tag);
    tb_check({tag, "_busy"}, busy40, 1'b0);
    tb_check({tag, "_op_ready"}, op_ready40, 1'b0);
    tb_check({tag, "_res_valid"}, res_valid40, 1'b0);
    tb_check({tag, "_res_data40"}, res_data40, 40'd0);
    tb_check({tag, "_res_ovf40"}, res_ovf40, 1'b0);
    tb_check({tag, "_res_data32"}, res_data32, 32'd0);
    tb_check({tag, "_res_ovf32"}, res_ovf32, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; len = 8'd0; op_valid = 1'b0;
    a_in = 16'd0; b_in = 16'd0; res_ready = 1'b0;
    #3;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    set_pairs(1, 2, 2);
    do_dot("single", 1, 0, 0);

    qa = '{1, 2, -4, 7};
    qb = '{1, 3, 5, -2};
    do_dot("four_gaps", 4, 0, 3);

    set_pairs(1, 2, 2);
    do_dot("hold5", 1, 5, 0);

    qa.delete(); qb.delete();
    do_dot("len0", 0, 1, 0);

    set_pairs(3, -32768, -32768);
    do_dot("sat", 3, 0, 1);
    set_pairs(1, 1, 1);
    do_dot("after_sat", 1, 0, 0);

    set_pairs(4, 5, 6);
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; len = 8'd0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; a_in = 16'd5; b_in = 16'd6;
      @(negedge clk);
    end
    op_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    set_pairs(1, 3, 3);
    do_dot("post_rst", 1, 0, 0);

    for (int t = 0; t < 24; t++) begin
      qa.delete(); qb.delete();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        if (t % 4 == 3) begin
          qa.push_back(($urandom_range(0, 1) != 0) ? -32768 : 32767);
          qb.push_back(-32768);
        end else begin
          qa.push_back(int'($urandom_range(0, 65535)) - 32768);
          qb.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
      end
      do_dot($sformatf("rand%0d", t), n, $urandom_range(0, 3), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
